// File: rtl/wb_register_file_if.sv
// wb_register_file_if
// Bus bundle between the pipeline (write-back producer, decode consumer)
// and the MIPS register file. The master modport is the pipeline side; the
// slave modport is the register file itself.
interface wb_register_file_if;
    logic        RegWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] WriteCount;
    logic [4:0]  LastWriteReg;
    logic [31:0] LastWriteData;

    modport master (
        output RegWriteW, WriteRegW, ResultW, A1, A2,
        input  RD1, RD2, WriteCount, LastWriteReg, LastWriteData
    );

    modport slave (
        input  RegWriteW, WriteRegW, ResultW, A1, A2,
        output RD1, RD2, WriteCount, LastWriteReg, LastWriteData
    );
endinterface

// File: rtl/wb_register_file.sv
// wb_register_file
// MIPS general-purpose register file: 31 storage registers (r0 is hardwired
// to zero), two combinational read ports, one write port fed by the
// write-back stage, plus a retired-write counter and last-commit record.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a write in the
// current cycle is forwarded to a read port addressing the same register.
module wb_register_file (
    input logic               CLK,
    input logic               rst,
    wb_register_file_if.slave bus
);

    logic [31:0] regs [1:31];
    logic [31:0] write_cnt;
    logic [4:0]  last_reg;
    logic [31:0] last_data;
    logic        commit;

    // Writes to r0 are architecturally discarded, so they never count as commits
    assign commit = bus.RegWriteW && (bus.WriteRegW != 5'd0);

    // Architectural register storage, cleared asynchronously by reset
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[bus.WriteRegW] <= bus.ResultW;
        end
    end

    // Retired-write counter and last-commit debug record
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            write_cnt <= '0;
            last_reg  <= '0;
            last_data <= '0;
        end else if (commit) begin
            write_cnt <= write_cnt + 32'd1;
            last_reg  <= bus.WriteRegW;
            last_data <= bus.ResultW;
        end
    end

    // Read port 1: zero during reset and for r0, otherwise stored or bypassed data
    always_comb begin
        bus.RD1 = '0;
        if (rst && (bus.A1 != 5'd0)) begin
`ifdef REGFILE_BYPASS_EN
            if (bus.RegWriteW && (bus.WriteRegW == bus.A1)) begin
                bus.RD1 = bus.ResultW;
            end else begin
                bus.RD1 = regs[bus.A1];
            end
`else
            bus.RD1 = regs[bus.A1];
`endif
        end
    end

    // Read port 2: same behaviour as port 1, addressed by A2
    always_comb begin
        bus.RD2 = '0;
        if (rst && (bus.A2 != 5'd0)) begin
`ifdef REGFILE_BYPASS_EN
            if (bus.RegWriteW && (bus.WriteRegW == bus.A2)) begin
                bus.RD2 = bus.ResultW;
            end else begin
                bus.RD2 = regs[bus.A2];
            end
`else
            bus.RD2 = regs[bus.A2];
`endif
        end
    end

    assign bus.WriteCount    = write_cnt;
    assign bus.LastWriteReg  = last_reg;
    assign bus.LastWriteData = last_data;

endmodule

// File: doc/wb_register_file.md
# wb_register_file

MIPS general-purpose register file: the write-back sink for the MEM/WB pipeline register and the operand source for the decode stage. It commits the write-back stage's result (RegWriteW, WriteRegW, ResultW) into one of 31 architectural registers, serves two combinational read ports to decode, and optionally bypasses a same-cycle write to the read ports. It also keeps a retired-write counter and a last-commit record for debug.

## Interface
- No parameters; fixed at 32 registers × 32 bits, 5-bit addresses.
- CLK  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- RegWriteW  input  1  write enable from the write-back stage.
- WriteRegW  input  5  destination register index from the write-back stage.
- ResultW  input  32  write data, already selected between ALUOutW and ReadDataW.
- A1  input  5  read address, port 1 (rs).
- A2  input  5  read address, port 2 (rt).
- RD1  output  32  read data, port 1.
- RD2  output  32  read data, port 2.
- WriteCount  output  32  number of committed writes to non-zero registers.
- LastWriteReg  output  5  index of the most recent committed write.
- LastWriteData  output  32  data of the most recent committed write.

## Operation
- Storage: registers 1..31 are flops. Register 0 has no storage and always reads 0.
- Commit: on a rising CLK edge, if RegWriteW=1 and WriteRegW≠0, then:
  - reg[WriteRegW] ← ResultW;
  - WriteCount ← WriteCount+1, wrapping modulo 2^32 (0xFFFFFFFF+1 → 0);
  - LastWriteReg ← WriteRegW;
  - LastWriteData ← ResultW.
- A write to register 0 is dropped completely: no state change and no count.
- RegWriteW=0: no state changes, whatever WriteRegW and ResultW hold.
- Reads: RDn is combinational from An. An=0 gives 0. Otherwise RDn = reg[An], or the bypassed value (see Configuration).
- A1=A2 is legal; both ports return the same value.
- Reset, when rst goes low at any time, including mid-cycle or during a write:
  - all 31 registers, WriteCount, LastWriteReg and LastWriteData go to 0 immediately;
  - RD1 and RD2 read 0 for as long as rst is low, with bypass suppressed;
  - a write presented on the edge where rst is released does not take effect if rst is still low at that edge.

## Timing
- Write latency: 1 edge. Data presented in cycle N is stored at the end of cycle N and is visible on RDn from cycle N+1 without bypass.
- Read latency: 0 cycles (combinational), aside from the bypass path below.
- WriteCount, LastWriteReg and LastWriteData update on the same edge as the commit.
- Reset values of all outputs: RD1=RD2=0, WriteCount=0, LastWriteReg=0, LastWriteData=0.
- Simultaneous read and write to the same non-zero register in one cycle: the result is determined by the Configuration macro.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: RDn = ResultW in the same cycle when all of the following hold: RegWriteW=1, WriteRegW=An, An≠0, and rst=1. This write-through removes the need for a WB→D hazard stall.
- Undefined: RDn always returns the stored value, i.e. the old value during the write cycle and the new value from the next cycle. The hazard unit must stall or forward for one cycle.
- In both builds, commits, counters and reset behaviour are identical.

## Test plan
- Reset: drive rst=0 with junk on all inputs. Every RDn for A1/A2 in 0..31 reads 0; WriteCount=0.
- Basic commit: write reg5=0xDEADBEEF, RegWriteW=1. On the next cycle A1=5 gives RD1=0xDEADBEEF; WriteCount=1; LastWriteReg=5; LastWriteData=0xDEADBEEF.
- Register 0: write WriteRegW=0, ResultW=0x12345678. RD1 at A1=0 stays 0; WriteCount is unchanged. Also present WriteRegW=7 with RegWriteW=0: reg7 is unchanged.
- Same-cycle read/write: reg9 holds 0x1, write 0x2 to it with A1=A2=9.
  - With REGFILE_BYPASS_EN: RD1=RD2=0x2 in the write cycle.
  - Without it: RD1=RD2=0x1 in the write cycle and 0x2 one cycle later.
- Counter wrap: preload WriteCount to 0xFFFFFFFE via 2^32−2 writes, or by forcing it in the bench, then make 2 commits. WriteCount=0x00000000.
- Reset mid-operation: fill reg1..reg31 with their index, then assert rst asynchronously between edges during a write to reg3. All registers and counters read 0 immediately, and reg3 stays 0 after release.
